// File: rtl/fb_pkg.sv
// Shared widths, FSM state encoding and pixel payload for the frame-buffer write scheduler.
package fb_pkg;

    localparam int unsigned COORD_W   = 11;
    localparam int unsigned COLOR_W   = 8;
    localparam int unsigned SUM_W     = COORD_W + 1;
    localparam int unsigned DEF_W_RES = 640;
    localparam int unsigned DEF_H_RES = 480;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        STAMP = 2'd2
    } fb_state_t;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COLOR_W-1:0] r;
        logic [COLOR_W-1:0] g;
        logic [COLOR_W-1:0] b;
    } fb_pixel_t;

endpackage

// File: rtl/fb_write_scheduler_if.sv
// Request side (clear/stamp) and shared frame-buffer write port of the scheduler.
interface fb_write_scheduler_if;
    import fb_pkg::*;

    logic               clear_req;
    logic               stamp_req;
    logic [COORD_W-1:0] stamp_x;
    logic [COORD_W-1:0] stamp_y;
    logic [COLOR_W-1:0] stamp_r;
    logic [COLOR_W-1:0] stamp_g;
    logic [COLOR_W-1:0] stamp_b;
    logic               stamp_ack;
    logic               clear_done;
    logic               busy;
    logic               wr_en;
    logic [COORD_W-1:0] wr_x;
    logic [COORD_W-1:0] wr_y;
    logic [COLOR_W-1:0] wr_r;
    logic [COLOR_W-1:0] wr_g;
    logic [COLOR_W-1:0] wr_b;

    // Scheduler side
    modport master (
        input  clear_req, stamp_req, stamp_x, stamp_y, stamp_r, stamp_g, stamp_b,
        output stamp_ack, clear_done, busy, wr_en, wr_x, wr_y, wr_r, wr_g, wr_b
    );

    // Requester / buffer side
    modport slave (
        output clear_req, stamp_req, stamp_x, stamp_y, stamp_r, stamp_g, stamp_b,
        input  stamp_ack, clear_done, busy, wr_en, wr_x, wr_y, wr_r, wr_g, wr_b
    );

endinterface

// File: rtl/fb_raster_counter.sv
// Nested x/y raster counter with runtime limits; done pulses the cycle after the last position is stepped past.
module fb_raster_counter
    import fb_pkg::*;
(
    input  logic               VGA_CLK,
    input  logic               reset,
    input  logic               start_i,
    input  logic               step_i,
    input  logic [COORD_W-1:0] x_max_i,
    input  logic [COORD_W-1:0] y_max_i,
    output logic [COORD_W-1:0] x_o,
    output logic [COORD_W-1:0] y_o,
    output logic               done_o
);

    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic               done_q, done_d;
    logic               last_c;

    assign last_c = (x_q == x_max_i) && (y_q == y_max_i);

    // Wraps back to the origin after the last position so the next run starts clean
    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        done_d = 1'b0;
        if (start_i) begin
            x_d = '0;
            y_d = '0;
        end else if (step_i) begin
            done_d = last_c;
            if (x_q == x_max_i) begin
                x_d = '0;
                y_d = (y_q == y_max_i) ? '0 : y_q + COORD_W'(1);
            end else begin
                x_d = x_q + COORD_W'(1);
            end
        end
    end

    always_ff @(posedge VGA_CLK) begin
        if (!reset) begin
            x_q    <= '0;
            y_q    <= '0;
            done_q <= 1'b0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            done_q <= done_d;
        end
    end

    assign x_o    = x_q;
    assign y_o    = y_q;
    assign done_o = done_q;

endmodule

// File: rtl/fb_write_scheduler.sv
// Arbitrates full-screen clear and cursor stamp into one registered frame-buffer write stream.
module fb_write_scheduler
    import fb_pkg::*;
#(
    parameter int unsigned        W_RES = DEF_W_RES,
    parameter int unsigned        H_RES = DEF_H_RES,
    parameter int unsigned        SIZE  = 16,
    parameter logic [COLOR_W-1:0] CLR_R = COLOR_W'(255),
    parameter logic [COLOR_W-1:0] CLR_G = COLOR_W'(255),
    parameter logic [COLOR_W-1:0] CLR_B = COLOR_W'(255)
)(
    input  logic                  VGA_CLK,
    input  logic                  reset,
    fb_write_scheduler_if.master  bus
);

    localparam logic [COORD_W-1:0] CLR_X_MAX = COORD_W'(W_RES - 1);
    localparam logic [COORD_W-1:0] CLR_Y_MAX = COORD_W'(H_RES - 1);
    localparam logic [COORD_W-1:0] STP_MAX   = COORD_W'(SIZE - 1);

    fb_state_t          state_q, state_d;
    logic               clear_pend_q, clear_pend_d;
    fb_pixel_t          stamp_q, stamp_d;
    fb_pixel_t          out_q, out_d;
    logic               wr_en_q, wr_en_d;
    logic               stamp_ack_q, stamp_ack_d;
    logic               clear_done_q, clear_done_d;
    logic               busy_q, busy_d;

    fb_pixel_t          base_c;
    logic [SUM_W-1:0]   sum_x_c, sum_y_c;
    logic               emit_clear_c, emit_stamp_c;
    logic               cnt_start_c, cnt_step_c;
    logic [COORD_W-1:0] cnt_x_max_c, cnt_y_max_c;
    logic [COORD_W-1:0] cnt_x, cnt_y;
    logic               cnt_done;

    fb_raster_counter u_raster (
        .VGA_CLK (VGA_CLK),
        .reset   (reset),
        .start_i (cnt_start_c),
        .step_i  (cnt_step_c),
        .x_max_i (cnt_x_max_c),
        .y_max_i (cnt_y_max_c),
        .x_o     (cnt_x),
        .y_o     (cnt_y),
        .done_o  (cnt_done)
    );

    // In IDLE the stamp inputs feed the first pixel directly, since latching happens on that same edge
    always_comb begin
        base_c = stamp_q;
        if (state_q == IDLE) begin
            base_c = '{x: bus.stamp_x, y: bus.stamp_y,
                       r: bus.stamp_r, g: bus.stamp_g, b: bus.stamp_b};
        end
    end

    assign sum_x_c = SUM_W'(base_c.x) + SUM_W'(cnt_x);
    assign sum_y_c = SUM_W'(base_c.y) + SUM_W'(cnt_y);

    always_comb begin
        state_d      = state_q;
        clear_pend_d = clear_pend_q;
        stamp_d      = stamp_q;
        out_d        = '0;
        wr_en_d      = 1'b0;
        stamp_ack_d  = 1'b0;
        clear_done_d = 1'b0;
        emit_clear_c = 1'b0;
        emit_stamp_c = 1'b0;
        cnt_start_c  = 1'b0;
        cnt_step_c   = 1'b0;

        if (bus.clear_req && (state_q != CLEAR)) begin
            clear_pend_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (clear_pend_q || bus.clear_req) begin
                    state_d      = CLEAR;
                    clear_pend_d = 1'b0;
                    emit_clear_c = 1'b1;
                    cnt_step_c   = 1'b1;
                end else if (bus.stamp_req) begin
                    state_d      = STAMP;
                    stamp_d      = base_c;
                    stamp_ack_d  = 1'b1;
                    emit_stamp_c = 1'b1;
                    cnt_step_c   = 1'b1;
                end else begin
                    cnt_start_c  = 1'b1;
                end
            end
            CLEAR: begin
                if (cnt_done) begin
                    state_d      = IDLE;
                    clear_done_d = 1'b1;
                end else begin
                    emit_clear_c = 1'b1;
                    cnt_step_c   = 1'b1;
                end
            end
            STAMP: begin
                if (cnt_done) begin
                    state_d = IDLE;
                end else begin
                    emit_stamp_c = 1'b1;
                    cnt_step_c   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d      = (state_d != IDLE);
        cnt_x_max_c = (state_d == CLEAR) ? CLR_X_MAX : STP_MAX;
        cnt_y_max_c = (state_d == CLEAR) ? CLR_Y_MAX : STP_MAX;

        // Clipped stamp pixels still consume a cycle but are not written
        if (emit_clear_c) begin
            wr_en_d = 1'b1;
            out_d   = '{x: cnt_x, y: cnt_y, r: CLR_R, g: CLR_G, b: CLR_B};
        end else if (emit_stamp_c) begin
            wr_en_d = (sum_x_c < SUM_W'(W_RES)) && (sum_y_c < SUM_W'(H_RES));
            out_d   = '{x: sum_x_c[COORD_W-1:0], y: sum_y_c[COORD_W-1:0],
                        r: base_c.r, g: base_c.g, b: base_c.b};
        end
    end

    always_ff @(posedge VGA_CLK) begin
        if (!reset) begin
            state_q      <= IDLE;
            clear_pend_q <= 1'b1;
            stamp_q      <= '0;
            out_q        <= '0;
            wr_en_q      <= 1'b0;
            stamp_ack_q  <= 1'b0;
            clear_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            clear_pend_q <= clear_pend_d;
            stamp_q      <= stamp_d;
            out_q        <= out_d;
            wr_en_q      <= wr_en_d;
            stamp_ack_q  <= stamp_ack_d;
            clear_done_q <= clear_done_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.wr_en      = wr_en_q;
    assign bus.wr_x       = out_q.x;
    assign bus.wr_y       = out_q.y;
    assign bus.wr_r       = out_q.r;
    assign bus.wr_g       = out_q.g;
    assign bus.wr_b       = out_q.b;
    assign bus.stamp_ack  = stamp_ack_q;
    assign bus.clear_done = clear_done_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_fb_write_scheduler.sv
// Directed bench for fb_write_scheduler on a reduced 120x70 screen with a 16x16 stamp.
module tb_fb_write_scheduler;

    localparam int unsigned W    = 120;
    localparam int unsigned H    = 70;
    localparam int unsigned S    = 16;
    localparam int unsigned NPIX = W * H;
    localparam int unsigned NST  = S * S;

    logic vga_clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 vga_clk = ~vga_clk;

    fb_write_scheduler_if bus ();

    fb_write_scheduler #(
        .W_RES (W),
        .H_RES (H),
        .SIZE  (S),
        .CLR_R (8'd255),
        .CLR_G (8'd255),
        .CLR_B (8'd255)
    ) dut (
        .VGA_CLK (vga_clk),
        .reset   (reset),
        .bus     (bus.master)
    );

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_stamp(input int x, input int y, input int r, input int g, input int b);
        bus.stamp_x   = 11'(x);
        bus.stamp_y   = 11'(y);
        bus.stamp_r   = 8'(r);
        bus.stamp_g   = 8'(g);
        bus.stamp_b   = 8'(b);
        bus.stamp_req = 1'b1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wr_en"}, 32'(bus.wr_en), 32'd0);
        chk({tag, "_xy"}, 32'({bus.wr_x, bus.wr_y}), 32'd0);
        chk({tag, "_rgb"}, 32'({bus.wr_r, bus.wr_g, bus.wr_b}), 32'd0);
        chk({tag, "_ack_done_busy"}, 32'({bus.stamp_ack, bus.clear_done, bus.busy}), 32'd0);
    endtask

    // Called in the first busy cycle of a clear; returns in the clear_done cycle
    task automatic collect_clear(input string tag);
        int ok = 0;
        logic [10:0] lx = '0;
        logic [10:0] ly = '0;
        for (int i = 0; i < int'(NPIX); i++) begin
            if (i == 0) begin
                chk({tag, "_first_xy"}, 32'({bus.wr_x, bus.wr_y}), 32'd0);
            end
            if (bus.busy === 1'b1 && bus.wr_en === 1'b1 &&
                bus.wr_x === 11'(i % W) && bus.wr_y === 11'(i / W) &&
                bus.wr_r === 8'hFF && bus.wr_g === 8'hFF && bus.wr_b === 8'hFF &&
                bus.stamp_ack === 1'b0 && bus.clear_done === 1'b0) begin
                ok++;
            end
            lx = bus.wr_x;
            ly = bus.wr_y;
            tick();
        end
        chk({tag, "_pixels_ok"}, 32'(ok), 32'(NPIX));
        chk({tag, "_last_x"}, 32'(lx), 32'(W - 1));
        chk({tag, "_last_y"}, 32'(ly), 32'(H - 1));
        chk({tag, "_end_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_end_wr_en"}, 32'(bus.wr_en), 32'd0);
        chk({tag, "_clear_done"}, 32'(bus.clear_done), 32'd1);
    endtask

    // Called in the ack cycle of a stamp; returns in the first IDLE cycle after it
    task automatic collect_stamp(input string tag, input int bx, input int by,
                                 input int r, input int g, input int b,
                                 input int clr_at, input int exp_en);
        int ok  = 0;
        int nen = 0;
        for (int i = 0; i < int'(NST); i++) begin
            int  sx;
            int  sy;
            logic en;
            sx = bx + (i % int'(S));
            sy = by + (i / int'(S));
            en = (sx < int'(W)) && (sy < int'(H));
            if (i == 0) begin
                chk({tag, "_ack"}, 32'(bus.stamp_ack), 32'd1);
            end
            if (bus.busy === 1'b1 && bus.stamp_ack === (i == 0) && bus.wr_en === en &&
                (!en || (bus.wr_x === 11'(sx) && bus.wr_y === 11'(sy) &&
                         bus.wr_r === 8'(r) && bus.wr_g === 8'(g) && bus.wr_b === 8'(b)))) begin
                ok++;
            end
            if (bus.wr_en === 1'b1) nen++;
            if (i == 0) bus.stamp_req = 1'b0;
            bus.clear_req = (i == clr_at);
            tick();
        end
        chk({tag, "_pixels_ok"}, 32'(ok), 32'(NST));
        chk({tag, "_written"}, 32'(nen), 32'(exp_en));
        chk({tag, "_end_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_end_wr_en_ack"}, 32'({bus.wr_en, bus.stamp_ack}), 32'd0);
    endtask

    initial begin
        reset         = 1'b0;
        bus.clear_req = 1'b0;
        bus.stamp_req = 1'b0;
        bus.stamp_x   = '0;
        bus.stamp_y   = '0;
        bus.stamp_r   = '0;
        bus.stamp_g   = '0;
        bus.stamp_b   = '0;
        repeat (3) tick();
        chk_all_zero("reset");

        // Power-up clear starts on the first edge with reset released
        reset = 1'b1;
        tick();
        chk("pwr_busy", 32'(bus.busy), 32'd1);
        collect_clear("pwr_clr");
        tick();
        chk("idle_after_clr", 32'({bus.busy, bus.clear_done}), 32'd0);

        set_stamp(100, 50, 0, 0, 100);
        tick();
        collect_stamp("st_plain", 100, 50, 0, 0, 100, -1, 256);
        tick();

        set_stamp(int'(W) - 10, int'(H) - 10, 1, 2, 3);
        tick();
        collect_stamp("st_clip", int'(W) - 10, int'(H) - 10, 1, 2, 3, -1, 100);

        // Clear request pulsed mid-stamp: stamp completes, one idle cycle, then clear
        set_stamp(10, 10, 200, 100, 50);
        tick();
        collect_stamp("st_then_clr", 10, 10, 200, 100, 50, 5, 256);
        chk("st_then_clr_no_done", 32'(bus.clear_done), 32'd0);
        tick();
        chk("st_then_clr_busy", 32'(bus.busy), 32'd1);
        collect_clear("clr_after_st");

        // Clear and stamp together: clear wins, stamp acked one idle cycle after clear_done
        bus.clear_req = 1'b1;
        set_stamp(30, 5, 9, 8, 7);
        tick();
        bus.clear_req = 1'b0;
        chk("both_busy", 32'(bus.busy), 32'd1);
        chk("both_no_ack", 32'(bus.stamp_ack), 32'd0);
        collect_clear("both_clr");
        chk("both_done_no_ack", 32'(bus.stamp_ack), 32'd0);
        tick();
        collect_stamp("both_st", 30, 5, 9, 8, 7, -1, 256);

        // Reset in the middle of a stamp
        tick();
        set_stamp(20, 20, 5, 6, 7);
        tick();
        bus.stamp_req = 1'b0;
        repeat (40) tick();
        chk("mid_st_xy", 32'({bus.wr_x, bus.wr_y}), 32'({11'd28, 11'd22}));
        reset = 1'b0;
        tick();
        chk_all_zero("mid_rst");
        reset = 1'b1;
        tick();
        chk("rst_clr_busy", 32'(bus.busy), 32'd1);
        collect_clear("rst_clr");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
